// File: rtl/cp_theta_slice_engine_pkg.sv
// Shared constants, state encoding and index helper for the theta slice engine.
package cp_theta_slice_engine_pkg;

    localparam int unsigned CP_SLICE_W = 25;
    localparam int unsigned CP_ADDR_W  = 6;
    localparam logic [CP_ADDR_W-1:0] CP_PRIME_ADDR = '1;
    localparam int unsigned CP_LANES   = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_DRAIN
    } state_e;

    function automatic int unsigned bit_idx(input int unsigned y, input int unsigned x);
        return CP_LANES * y + x;
    endfunction

endpackage

// File: rtl/cp_theta_slice_engine_column_parity.sv
// Column parity of one 5x5 slice: C[x] = XOR over y of slice[5y+x].
module cp_column_parity
    import cp_theta_slice_engine_pkg::*;
(
    input  logic [CP_SLICE_W-1:0] slice_i,
    output logic [CP_LANES-1:0]   parity_o
);

    always_comb begin
        parity_o = '0;
        for (int unsigned x = 0; x < CP_LANES; x++) begin
            for (int unsigned y = 0; y < CP_LANES; y++) begin
                parity_o[x] = parity_o[x] ^ slice_i[bit_idx(y, x)];
            end
        end
    end

endmodule

// File: rtl/cp_theta_slice_engine.sv
// Theta pass over a 64-slice state: primes with slice 63, then reads, corrects
// and writes back slices 0..63 at one slice per cycle.
module cp_theta_slice_engine
    import cp_theta_slice_engine_pkg::*;
#(
    parameter int unsigned ADDR_W  = CP_ADDR_W,
    parameter int unsigned SLICE_W = CP_SLICE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [SLICE_W-1:0] rd_data,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [SLICE_W-1:0] wr_data,
    output logic               busy,
    output logic               done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                drain_q, drain_d;

    logic                rd_vld_q;
    logic                rd_prime_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [CP_LANES-1:0] prev_c_q;
    logic [CP_LANES-1:0] c_cur;
    logic [CP_LANES-1:0] d_col;
    logic [SLICE_W-1:0]  theta_out;

    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [SLICE_W-1:0]  wr_data_q;
    logic                done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        rd_en   = 1'b0;
        rd_addr = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                rd_en   = 1'b1;
                rd_addr = LAST_ADDR;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                rd_en   = 1'b1;
                rd_addr = cnt_q;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = ST_IDLE;
                    drain_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    cp_column_parity u_parity (
        .slice_i  (rd_data),
        .parity_o (c_cur)
    );

    always_comb begin
        d_col     = '0;
        theta_out = rd_data;
        for (int unsigned x = 0; x < CP_LANES; x++) begin
            d_col[x] = c_cur[(x + 4) % CP_LANES] ^ prev_c_q[(x + 1) % CP_LANES];
        end
        for (int unsigned y = 0; y < CP_LANES; y++) begin
            for (int unsigned x = 0; x < CP_LANES; x++) begin
                theta_out[bit_idx(y, x)] = rd_data[bit_idx(y, x)] ^ d_col[x];
            end
        end
    end

    // Read-side tags follow the synchronous memory by one cycle; the prime read
    // only loads prev_c and never produces a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_q   <= 1'b0;
            rd_prime_q <= 1'b0;
            rd_addr_q  <= '0;
            prev_c_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            rd_vld_q   <= rd_en;
            rd_prime_q <= (state_q == ST_PRIME);
            rd_addr_q  <= rd_addr;
            if (rd_vld_q) prev_c_q <= c_cur;
            wr_en_q <= rd_vld_q & ~rd_prime_q;
            done_q  <= rd_vld_q & ~rd_prime_q & (rd_addr_q == LAST_ADDR);
            if (rd_vld_q && !rd_prime_q) begin
                wr_addr_q <= rd_addr_q;
                wr_data_q <= theta_out;
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;

endmodule

// File: tb/tb_cp_theta_slice_engine.sv
// Self-checking bench: table-driven passes plus reset-abort, held-start and back-to-back runs.
`timescale 1ns/1ps
module tb_cp_theta_slice_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [24:0] rd_data;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [24:0] wr_data;
    logic        busy;
    logic        done;

    cp_theta_slice_engine #(.ADDR_W(6), .SLICE_W(25)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    logic [24:0] mem [64];
    logic [24:0] cap [64];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    typedef struct {
        logic [5:0]  a;
        logic [24:0] d;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic [24:0] rest, s0, s1, s63;
        logic [24:0] exp0, exp1, exp63, exp_rest;
    } vec_t;
    vec_t vecs [5];

    int total = 0;
    int passed = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [24:0] theta_model(input logic [24:0] s, input logic [24:0] p);
        logic [24:0] col = 25'h0108421;
        logic [4:0]  cc, cp;
        logic [24:0] r = s;
        for (int x = 0; x < 5; x++) begin
            cc[x] = ^(s & (col << x));
            cp[x] = ^(p & (col << x));
        end
        for (int x = 0; x < 5; x++)
            if (cc[(x + 4) % 5] ^ cp[(x + 1) % 5]) r = r ^ (col << x);
        return r;
    endfunction

    function automatic void push_expected();
        wr_t e;
        for (int z = 0; z < 64; z++) begin
            e.a = 6'(z);
            e.d = theta_model(mem[z], mem[(z + 63) % 64]);
            sb.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (wr_en) begin
            wr_t e;
            wr_cnt++;
            cap[wr_addr] = wr_data;
            if (sb.size() == 0) chk("unexpected write", 32'(wr_addr), 32'hffff_ffff);
            else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.a));
                chk("wr_data", 32'(wr_data), 32'(e.d));
            end
        end
        if (done) done_cnt++;
    end

    // Called at a negedge; that cycle is cycle 0 (start sampled at its end).
    task automatic run_pass(input int hold);
        wr_cnt = 0;
        done_cnt = 0;
        for (int z = 0; z < 64; z++) cap[z] = 'x;
        push_expected();
        start = 1'b1;
        for (int k = 1; k <= 68; k++) begin
            @(negedge clk);
            if (k >= hold) start = 1'b0;
            chk("busy", 32'(busy), 32'(k <= 67));
            chk("done", 32'(done), 32'(k == 67));
            if (k == 1)  chk("prime read", {25'd0, rd_en, rd_addr}, {25'd0, 1'b1, 6'd63});
            if (k == 2)  chk("first run read", {25'd0, rd_en, rd_addr}, {25'd0, 1'b1, 6'd0});
            if (k == 65) chk("last run read", {25'd0, rd_en, rd_addr}, {25'd0, 1'b1, 6'd63});
            if (k == 66) chk("rd_en after run", 32'(rd_en), 32'd0);
            if (k == 3)  chk("no write before cycle 4", 32'(wr_en), 32'd0);
            if (k == 4)  chk("first write", {25'd0, wr_en, wr_addr}, {25'd0, 1'b1, 6'd0});
            if (k == 68) chk("no write after cycle 67", 32'(wr_en), 32'd0);
        end
        chk("write count", 32'(wr_cnt), 32'd64);
        chk("done count", 32'(done_cnt), 32'd1);
        chk("scoreboard empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{rest: 25'h0, s0: 25'h0, s1: 25'h0, s63: 25'h0,
                    exp0: 25'h0, exp1: 25'h0, exp63: 25'h0, exp_rest: 25'h0};
        vecs[1] = '{rest: 25'h0, s0: 25'h0000001, s1: 25'h0, s63: 25'h0,
                    exp0: 25'h0210843, exp1: 25'h1084210, exp63: 25'h0, exp_rest: 25'h0};
        vecs[2] = '{rest: 25'h0, s0: 25'h0, s1: 25'h0, s63: 25'h0000001,
                    exp0: 25'h1084210, exp1: 25'h0, exp63: 25'h0210843, exp_rest: 25'h0};
        vecs[3] = '{rest: 25'h0000021, s0: 25'h0000021, s1: 25'h0000021, s63: 25'h0000021,
                    exp0: 25'h0000021, exp1: 25'h0000021, exp63: 25'h0000021, exp_rest: 25'h0000021};
        vecs[4] = '{rest: 25'h0, s0: 25'h1ffffff, s1: 25'h0, s63: 25'h0,
                    exp0: 25'h0, exp1: 25'h1ffffff, exp63: 25'h0, exp_rest: 25'h0};

        reset = 1'b1;
        start = 1'b0;
        for (int z = 0; z < 64; z++) mem[z] = '0;
        repeat (3) @(negedge clk);
        chk("reset outputs", {rd_en, wr_en, busy, done, rd_addr, wr_addr},
            {4'b0000, 6'd0, 6'd0});
        chk("reset wr_data", 32'(wr_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle after reset", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            for (int z = 0; z < 64; z++) mem[z] = vecs[i].rest;
            mem[0]  = vecs[i].s0;
            mem[1]  = vecs[i].s1;
            mem[63] = vecs[i].s63;
            run_pass(1);
            chk($sformatf("vec%0d slice0", i), 32'(cap[0]), 32'(vecs[i].exp0));
            chk($sformatf("vec%0d slice1", i), 32'(cap[1]), 32'(vecs[i].exp1));
            chk($sformatf("vec%0d slice63", i), 32'(cap[63]), 32'(vecs[i].exp63));
            for (int z = 2; z < 63; z++)
                chk($sformatf("vec%0d slice%0d", i, z), 32'(cap[z]), 32'(vecs[i].exp_rest));
        end

        for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
        run_pass(1);

        // Reset in cycle 30 of a pass.
        for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
        push_expected();
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk("abort outputs", {rd_en, wr_en, busy, done, rd_addr, wr_addr},
            {4'b0000, 6'd0, 6'd0});
        chk("abort wr_data", 32'(wr_data), 32'd0);
        sb.delete();
        @(negedge clk);
        chk("abort next cycle", {29'd0, rd_en, wr_en, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle after abort", {31'd0, busy}, 32'd0);
        for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
        run_pass(1);

        // Start held for 10 cycles, then a new start in cycle 68.
        for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
        run_pass(10);
        run_pass(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
